// File: rtl/read_sched.sv
// Round-robin arbiter that lends one multi-beat read engine to NREQ requesters
// and sequences start / beat / last, returning a done or abort pulse to the owner.
//
// state  | meaning
// IDLE   | no owner; scan req from ptr upward, latch owner and len
// START  | one-cycle engine start strobe
// READ   | beats pass while eng_ready is high; cnt counts down to the last beat
// FINISH | done or abort pulse to owner; advance ptr past owner
module read_sched #(
  parameter int NREQ = 4,
  parameter int LENW = 4
) (
  input  logic                     clock,
  input  logic                     reset_L,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LENW-1:0]     len,
  input  logic                     eng_ready,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          abort,
  output logic                     eng_start,
  output logic                     eng_beat,
  output logic                     eng_last,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, READ, FINISH} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [LENW-1:0] cnt;
  logic            aborted;

  logic            pick_valid;
  logic [IW-1:0]   pick;
  logic [LENW-1:0] pick_len;
  int              idx;
  logic [NREQ-1:0] owner_hot;
  logic            owner_req;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    pick_len   = '0;
    idx        = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick       = IW'(idx);
        pick_len   = len[idx*LENW +: LENW];
      end
    end
  end

  assign owner_hot = NREQ'(1) << owner;
  assign owner_req = |(req & owner_hot);

  assign busy      = (state != IDLE);
  assign gnt       = busy ? owner_hot : '0;
  assign eng_start = (state == START);
  assign done      = (state == FINISH && !aborted) ? owner_hot : '0;
  assign abort     = (state == FINISH && aborted) ? owner_hot : '0;
  // A dropped request suppresses the beat in the same cycle it is seen.
  assign eng_beat  = (state == READ) && eng_ready && owner_req;
  assign eng_last  = eng_beat && (cnt == '0);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      aborted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            cnt   <= pick_len;
            state <= START;
          end
        end
        START: begin
          if (!owner_req) begin
            aborted <= 1'b1;
            state   <= FINISH;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          if (!owner_req) begin
            aborted <= 1'b1;
            state   <= FINISH;
          end else if (eng_ready) begin
            if (cnt == '0) state <= FINISH;
            else           cnt   <= cnt - 1'b1;
          end
        end
        FINISH: begin
          ptr     <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
          aborted <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_sched.sv
// Directed bench for read_sched: single read, rotation, stalls, aborts and
// mid-transaction reset, with hand-computed expectations per cycle.
module tb_read_sched;
  localparam int NREQ = 4;
  localparam int LENW = 4;

  logic                 clock = 1'b0;
  logic                 reset_L;
  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] len;
  logic                 eng_ready;
  logic [NREQ-1:0]      gnt, done, abort;
  logic                 eng_start, eng_beat, eng_last, busy;
  logic [1:0]           owner;

  int checks = 0;
  int errors = 0;
  logic rdy_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clock = ~clock;

  read_sched #(.NREQ(NREQ), .LENW(LENW)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .req       (req),
    .len       (len),
    .eng_ready (eng_ready),
    .gnt       (gnt),
    .done      (done),
    .abort     (abort),
    .eng_start (eng_start),
    .eng_beat  (eng_beat),
    .eng_last  (eng_last),
    .owner     (owner),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] g, input logic s, input logic b,
                    input logic l, input logic [3:0] d, input logic [3:0] a);
    chk({tag, "_gnt"},   32'(gnt),       32'(g));
    chk({tag, "_start"}, 32'(eng_start), 32'(s));
    chk({tag, "_beat"},  32'(eng_beat),  32'(b));
    chk({tag, "_last"},  32'(eng_last),  32'(l));
    chk({tag, "_done"},  32'(done),      32'(d));
    chk({tag, "_abort"}, 32'(abort),     32'(a));
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_L   = 1'b1;
    req       = '0;
    len       = '0;
    eng_ready = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    st("rst", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    cyc(); cyc();
    reset_L = 1'b1;

    // single request, owner 2, len 3
    cyc(); req = 4'b0100; len = 16'h0300; #1;
    st("t1_idle", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    cyc(); #1;
    st("t1_start", 4'b0100, 1, 0, 0, 4'b0000, 4'b0000);
    chk("t1_owner", 32'(owner), 2);
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      st("t1_beat", 4'b0100, 0, 1, (i == 3), 4'b0000, 4'b0000);
    end
    cyc(); #1;
    st("t1_done", 4'b0100, 0, 0, 0, 4'b0100, 4'b0000);
    cyc(); req = '0; #1;
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_owner", 32'(owner), 2);
    st("t1_end", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);

    // reset in IDLE clears ptr (was 3)
    cyc(); reset_L = 1'b0; #1;
    chk("rst2_owner", 32'(owner), 0);
    cyc(); cyc();
    reset_L = 1'b1;

    // all four requesting, len 0: rotation 0,1,2,3,0 with starts 4 cycles apart
    cyc(); req = 4'b1111; len = '0; #1;
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk("rr_start", 32'(eng_start), 1);
      chk("rr_owner", 32'(owner), 32'(k % 4));
      chk("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
      if (k == 4) req = 4'b0001;
      for (int j = 0; j < 3; j++) begin
        if (k == 4 && j == 2) begin
          cyc(); req = '0; #1;
        end else begin
          cyc(); #1;
        end
        chk("rr_nostart", 32'(eng_start), 0);
        if (j == 0) chk("rr_last", 32'(eng_last), 1);
        if (j == 1) chk("rr_done", 32'(done), 32'(1) << (k % 4));
        if (j == 2) chk("rr_idle", 32'(busy), 0);
      end
    end

    // stalls: owner 1, len 2, ready low on 2nd and 3rd READ cycles
    cyc(); req = 4'b0010; len = 16'h0020; #1;
    cyc(); #1;
    st("stall_start", 4'b0010, 1, 0, 0, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cyc(); eng_ready = rdy_pat[i]; #1;
      st("stall_rd", 4'b0010, 0, rdy_pat[i], (i == 4), 4'b0000, 4'b0000);
    end
    cyc(); #1;
    st("stall_done", 4'b0010, 0, 0, 0, 4'b0010, 4'b0000);
    cyc(); req = '0; eng_ready = 1'b1; #1;
    chk("stall_idle", 32'(busy), 0);

    // reset during READ with ptr=2; afterwards 1010 must grant 1 (ptr back at 0)
    cyc(); req = 4'b0100; len = 16'h0300; #1;
    cyc(); #1;
    chk("mr_owner", 32'(owner), 2);
    cyc(); #1;
    chk("mr_beat", 32'(eng_beat), 1);
    cyc(); reset_L = 1'b0; req = 4'b1010; len = '0; #1;
    st("mr_rst", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_owner0", 32'(owner), 0);
    cyc(); reset_L = 1'b1; #1;
    chk("mr_idle", 32'(busy), 0);
    cyc(); #1;
    st("mr_regrant", 4'b0010, 1, 0, 0, 4'b0000, 4'b0000);
    chk("mr_regrant_owner", 32'(owner), 1);
    cyc(); #1;
    st("mr_beat2", 4'b0010, 0, 1, 1, 4'b0000, 4'b0000);
    cyc(); #1;
    st("mr_done", 4'b0010, 0, 0, 0, 4'b0010, 4'b0000);
    cyc(); req = '0; #1;
    chk("mr_end", 32'(busy), 0);

    // abort after 1 of 5 beats; owner 2, requester 3 then served
    cyc(); req = 4'b1100; len = 16'h0400; #1;
    cyc(); #1;
    st("ab_start", 4'b0100, 1, 0, 0, 4'b0000, 4'b0000);
    cyc(); #1;
    st("ab_beat", 4'b0100, 0, 1, 0, 4'b0000, 4'b0000);
    cyc(); req = 4'b1000; #1;
    st("ab_drop", 4'b0100, 0, 0, 0, 4'b0000, 4'b0000);
    cyc(); #1;
    st("ab_pulse", 4'b0100, 0, 0, 0, 4'b0000, 4'b0100);
    cyc(); #1;
    st("ab_idle", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    cyc(); #1;
    st("ab_next", 4'b1000, 1, 0, 0, 4'b0000, 4'b0000);
    chk("ab_next_owner", 32'(owner), 3);
    cyc(); #1;
    st("ab_next_beat", 4'b1000, 0, 1, 1, 4'b0000, 4'b0000);
    cyc(); #1;
    st("ab_next_done", 4'b1000, 0, 0, 0, 4'b1000, 4'b0000);
    cyc(); req = '0; #1;
    chk("ab_end", 32'(busy), 0);

    // drop in the cycle of the last beat: abort wins, no beat, no done
    cyc(); req = 4'b0001; len = 16'h0001; #1;
    cyc(); #1;
    st("al_start", 4'b0001, 1, 0, 0, 4'b0000, 4'b0000);
    cyc(); #1;
    st("al_beat", 4'b0001, 0, 1, 0, 4'b0000, 4'b0000);
    cyc(); req = '0; #1;
    st("al_drop", 4'b0001, 0, 0, 0, 4'b0000, 4'b0000);
    cyc(); #1;
    st("al_pulse", 4'b0001, 0, 0, 0, 4'b0000, 4'b0001);
    cyc(); #1;
    st("al_idle", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    chk("al_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
